// File: rtl/obstacle_spawner_pkg.sv
// ============================================================================
// Module      : dinorun_pkg
// Description : Shared types and constants for the obstacle spawner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dinorun_pkg;

    typedef enum logic [1:0] {
        SpIdle  = 2'd0,
        SpGap   = 2'd1,
        SpSpawn = 2'd2
    } spawner_state_e;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

    // An all-zero LFSR would lock up, so a zero seed becomes 1
    function automatic logic [15:0] eff_seed(input logic [15:0] seed);
        return (seed == 16'h0000) ? 16'h0001 : seed;
    endfunction

endpackage

`default_nettype wire

// File: rtl/obstacle_spawner_lfsr.sv
// ============================================================================
// Module      : spawn_lfsr
// Description : 16-bit Galois LFSR that advances only when step_i is high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spawn_lfsr
    import dinorun_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        step_i,
    output logic [15:0] state_o,
    output logic [15:0] next_o
);

    localparam logic [15:0] c_SEED = eff_seed(SEED);

    logic [15:0] r_state;
    logic [15:0] w_next;

    always_comb begin
        w_next = {1'b0, r_state[15:1]};
        if (r_state[0]) begin
            w_next = w_next ^ c_LFSR_TAPS;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= c_SEED;
        end else if (step_i) begin
            r_state <= w_next;
        end
    end

    assign state_o = r_state;
    assign next_o  = w_next;

endmodule

`default_nettype wire

// File: rtl/obstacle_spawner.sv
// ============================================================================
// Module      : obstacle_spawner
// Description : Frame-rate obstacle scheduler: picks spawn timing and kind,
//               and supplies a per-frame random byte to the obstacles.
//               Optional macro SPAWNER_BIRD_EN enables bird selection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module obstacle_spawner #(
    parameter int          MIN_GAP       = 40,
    parameter int          GAP_FLOOR     = 16,
    parameter int          RAND_GAP_BITS = 5,
    parameter int          BIRD_LEVEL    = 2,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       next_frame_i,
    input  logic       run_i,
    input  logic [3:0] level_i,
    output logic       cactus_spawn_o,
    output logic       bird_spawn_o,
    output logic [7:0] rand_o
);

    import dinorun_pkg::*;

    // Two guard bits above the LFSR width keep base + random extra from wrapping
    localparam int                 c_CNT_W     = 18;
    localparam logic [15:0]        c_SEED      = eff_seed(LFSR_SEED);
    localparam logic [c_CNT_W-1:0] c_MIN       = c_CNT_W'(MIN_GAP);
    localparam logic [c_CNT_W-1:0] c_FLOOR     = c_CNT_W'(GAP_FLOOR);
    localparam logic [c_CNT_W-1:0] c_MASK      = c_CNT_W'((32'd1 << RAND_GAP_BITS) - 32'd1);
    localparam logic [3:0]         c_BIRD_LVL  = 4'(BIRD_LEVEL);
`ifdef SPAWNER_BIRD_EN
    localparam logic               c_BIRD_EN   = 1'b1;
`else
    localparam logic               c_BIRD_EN   = 1'b0;
`endif

    spawner_state_e     r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_cactus;
    logic               r_bird;
    logic [7:0]         r_rand;

    logic [15:0]        w_lfsr;
    logic [15:0]        w_lfsr_next;
    logic [c_CNT_W-1:0] w_dec;
    logic [c_CNT_W-1:0] w_base;
    logic [c_CNT_W-1:0] w_gap;
    logic               w_bird;

    spawn_lfsr #(
        .SEED    (c_SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .step_i  (next_frame_i),
        .state_o (w_lfsr),
        .next_o  (w_lfsr_next)
    );

    // Compare before subtracting so a high level clamps instead of wrapping
    assign w_dec  = {{(c_CNT_W-5){1'b0}}, level_i, 1'b0};
    assign w_base = (c_MIN >= w_dec + c_FLOOR) ? (c_MIN - w_dec) : c_FLOOR;
    assign w_gap  = w_base + ({2'b00, w_lfsr} & c_MASK);
    assign w_bird = c_BIRD_EN && (level_i >= c_BIRD_LVL) && (w_lfsr[15:14] == 2'b11);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= SpIdle;
            r_cnt    <= '0;
            r_cactus <= 1'b0;
            r_bird   <= 1'b0;
            r_rand   <= c_SEED[7:0];
        end else begin
            if (next_frame_i) begin
                r_rand <= w_lfsr_next[7:0];
            end
            if (!run_i) begin
                r_state  <= SpIdle;
                r_cnt    <= '0;
                r_cactus <= 1'b0;
                r_bird   <= 1'b0;
            end else if (next_frame_i) begin
                case (r_state)
                    SpIdle: begin
                        r_cnt   <= w_gap;
                        r_state <= SpGap;
                    end
                    SpGap: begin
                        if (r_cnt == '0) begin
                            r_state  <= SpSpawn;
                            r_bird   <= w_bird;
                            r_cactus <= !w_bird;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    SpSpawn: begin
                        r_cactus <= 1'b0;
                        r_bird   <= 1'b0;
                        r_cnt    <= w_gap;
                        r_state  <= SpGap;
                    end
                    default: begin
                        r_state <= SpIdle;
                    end
                endcase
            end
        end
    end

    assign cactus_spawn_o = r_cactus;
    assign bird_spawn_o   = r_bird;
    assign rand_o         = r_rand;

endmodule

`default_nettype wire

// File: tb/tb_obstacle_spawner.sv
// ============================================================================
// Module      : tb_obstacle_spawner
// Description : Self-checking bench for obstacle_spawner (default random gap
//               and a zero-random-gap instance side by side).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obstacle_spawner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       next_frame;
    logic       run;
    logic [3:0] level;

    logic       cac_a, bird_a, cac_b, bird_b;
    logic [7:0] rnd_a, rnd_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: one shared LFSR, per-instance spawn schedule
    logic [15:0] m_lfsr;
    int          frame_no;
    bit          m_run  [2];
    bit          m_pend [2];
    int          m_next [2];
    bit          m_cac  [2];
    bit          m_bird [2];

    always #5 clk = ~clk;

    obstacle_spawner u_dut_a (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .next_frame_i   (next_frame),
        .run_i          (run),
        .level_i        (level),
        .cactus_spawn_o (cac_a),
        .bird_spawn_o   (bird_a),
        .rand_o         (rnd_a)
    );

    obstacle_spawner #(
        .RAND_GAP_BITS  (0)
    ) u_dut_b (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .next_frame_i   (next_frame),
        .run_i          (run),
        .level_i        (level),
        .cactus_spawn_o (cac_b),
        .bird_spawn_o   (bird_b),
        .rand_o         (rnd_b)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic int gap_of(input int rgb, input logic [15:0] l, input int lvl);
        int b;
        b = 40 - 2 * lvl;
        if (b < 16) b = 16;
        return b + (int'(l) & ((1 << rgb) - 1));
    endfunction

    function automatic bit is_bird(input logic [15:0] l, input int lvl);
`ifdef SPAWNER_BIRD_EN
        return (lvl >= 2) && (l[15:14] == 2'b11);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [15:0] pre;
        int g;
        if (!rst_n) begin
            m_lfsr = 16'hACE1;
            for (int i = 0; i < 2; i++) begin
                m_run[i] = 0; m_pend[i] = 0; m_cac[i] = 0; m_bird[i] = 0;
            end
        end else begin
            pre = m_lfsr;
            if (next_frame) begin
                frame_no++;
                m_lfsr = lfsr_step(m_lfsr);
            end
            for (int i = 0; i < 2; i++) begin
                g = gap_of((i == 0) ? 5 : 0, pre, int'(level));
                if (!run) begin
                    m_run[i] = 0; m_pend[i] = 0; m_cac[i] = 0; m_bird[i] = 0;
                end else if (next_frame) begin
                    if (!m_run[i]) begin
                        m_run[i]  = 1;
                        m_next[i] = frame_no + g + 1;
                    end else if (m_pend[i]) begin
                        m_pend[i] = 0; m_cac[i] = 0; m_bird[i] = 0;
                        m_next[i] = frame_no + g + 1;
                    end else if (frame_no == m_next[i]) begin
                        m_bird[i] = is_bird(pre, int'(level));
                        m_cac[i]  = !m_bird[i];
                        m_pend[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("cactus_a", 32'(cac_a),  32'(m_cac[0]));
        chk("bird_a",   32'(bird_a), 32'(m_bird[0]));
        chk("rand_a",   32'(rnd_a),  32'(m_lfsr[7:0]));
        chk("cactus_b", 32'(cac_b),  32'(m_cac[1]));
        chk("bird_b",   32'(bird_b), 32'(m_bird[1]));
        chk("rand_b",   32'(rnd_b),  32'(m_lfsr[7:0]));
        chk("exclusive_a", 32'(cac_a & bird_a), 32'd0);
    endtask

    task automatic frame(input int idle);
        next_frame = 1'b1;
        step();
        next_frame = 1'b0;
        repeat (idle) step();
    endtask

    // Frames until instance b shows a spawn, bounded
    task automatic wait_spawn_b(output int n);
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            frame(1);
            if (cac_b || bird_b) begin
                n = k;
                return;
            end
        end
        chk("spawn_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        frame_no   = 0;
        rst_n      = 1'b0;
        run        = 1'b0;
        next_frame = 1'b0;
        level      = 4'd0;
        step();
        step();
        rst_n = 1'b1;
        chk("reset_rand", 32'(rnd_a), 32'h00E1);
        chk("reset_spawn", 32'({cac_a, bird_a, cac_b, bird_b}), 32'd0);

        // Idle: no spawns while LFSR still advances
        repeat (10) frame(1);

        // Zero random gap, level 0: first spawn 41 frames, then period 42
        run = 1'b1;
        frame(1);
        wait_spawn_b(n);
        chk("first_gap_l0", 32'(n), 32'd41);
        wait_spawn_b(n);
        chk("period_l0", 32'(n), 32'd42);

        // High level clamps to the floor: period 18
        level = 4'd15;
        wait_spawn_b(n);
        wait_spawn_b(n);
        chk("period_l15", 32'(n), 32'd18);

        // Abort mid-spawn, then restart at level 0
        wait_spawn_b(n);
        run = 1'b0;
        step();
        chk("abort_cactus_b", 32'(cac_b), 32'd0);
        repeat (3) step();
        level = 4'd0;
        run   = 1'b1;
        frame(1);
        wait_spawn_b(n);
        chk("restart_gap", 32'(n), 32'd41);

        // Long randomized run at a bird-capable level
        level = 4'd3;
        repeat (2000) frame(int'($urandom_range(0, 2)));

        // Reset mid-gap then replay
        level = 4'd0;
        repeat (5) frame(1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midreset_rand", 32'(rnd_b), 32'h00E1);
        chk("midreset_spawn", 32'({cac_a, bird_a, cac_b, bird_b}), 32'd0);
        frame(1);
        wait_spawn_b(n);
        chk("replay_gap", 32'(n), 32'd41);
        repeat (100) frame(int'($urandom_range(0, 3)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
